// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding,
// parity modes and the configuration legality check used at elaboration.
package uart_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_START  = ENC_START,
    ST_DATA   = ENC_DATA,
    ST_PARITY = ENC_PARITY,
    ST_STOP   = ENC_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic bit cfg_legal(input int data_bits, input int oversample,
                                   input int parity, input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && (oversample <= 32) && (oversample % 2 == 0) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Rx front end: 2-flop synchronizer plus a 3-sample majority vote whose
// newest sample is the live synchronized value at the current clken tick.
module uart_rx_sampler (
  input  logic clk_50m,
  input  logic rst,
  input  logic clken,
  input  logic Rx,
  output logic rx_s,
  output logic bit_val
);

  logic       sync1;
  logic [1:0] hist;
  logic [2:0] window;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= Rx;
      rx_s  <= sync1;
    end
  end

  // hist holds the two previous ticks so the vote at tick M+1 sees M-1, M, M+1
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (clken) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign window  = {hist, rx_s};
  assign bit_val = (window[2] & window[1]) | (window[2] & window[0]) |
                   (window[1] & window[0]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start/data/parity/stop framing on clken ticks,
// committing each word mid final stop bit with sticky ready/overrun flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 Rx,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam bit CFG_OK = cfg_legal(DATA_BITS, OVERSAMPLE, PARITY, STOP_BITS);

  if (!CFG_OK) begin : g_bad_cfg
    $error("uart_rx_param: illegal DATA_BITS/OVERSAMPLE/PARITY/STOP_BITS combination");
  end

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST  = (STOP_BITS == 2);
  localparam logic              PAR_EXPECT = (PARITY == PAR_ODD);

  logic rx_s;
  logic bit_val;

  uart_rx_sampler u_sampler (
    .clk_50m (clk_50m),
    .rst     (rst),
    .clken   (clken),
    .Rx      (Rx),
    .rx_s    (rx_s),
    .bit_val (bit_val)
  );

  state_t                state, state_nxt;
  logic [TICK_W-1:0]     tick, tick_nxt, tick_adv;
  logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
  logic                  stop_idx, stop_idx_nxt;
  logic                  stop_low, stop_low_nxt;
  logic                  par_bit, par_bit_nxt;
  logic [DATA_BITS-1:0]  scratch, scratch_nxt;
  logic                  commit;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop_low <= 1'b0;
      par_bit  <= 1'b0;
      scratch  <= '0;
    end else begin
      state    <= state_nxt;
      tick     <= tick_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      stop_low <= stop_low_nxt;
      par_bit  <= par_bit_nxt;
      scratch  <= scratch_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    stop_low_nxt = stop_low;
    par_bit_nxt  = par_bit;
    scratch_nxt  = scratch;
    commit       = 1'b0;
    tick_adv     = (tick == TICK_LAST) ? '0 : tick + 1'b1;

    if (clken) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt    = ST_START;
            tick_nxt     = TICK_W'(1);
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
            stop_low_nxt = 1'b0;
          end
        end
        ST_START: begin
          tick_nxt = tick_adv;
          if (tick == TICK_MID && bit_val) begin
            state_nxt = ST_IDLE;
            tick_nxt  = '0;
          end else if (tick == TICK_LAST) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end
        end
        ST_DATA: begin
          tick_nxt = tick_adv;
          if (tick == TICK_MID) scratch_nxt[bit_idx] = bit_val;
          if (tick == TICK_LAST) begin
            if (bit_idx == IDX_LAST) begin
              state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_nxt = bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          tick_nxt = tick_adv;
          if (tick == TICK_MID)  par_bit_nxt = bit_val;
          if (tick == TICK_LAST) state_nxt   = ST_STOP;
        end
        ST_STOP: begin
          // commit mid final stop bit so the next start edge can be caught early
          tick_nxt = tick_adv;
          if (tick == TICK_MID) begin
            if (stop_idx == STOP_LAST) begin
              commit    = 1'b1;
              state_nxt = ST_IDLE;
              tick_nxt  = '0;
            end else begin
              stop_low_nxt = stop_low | ~bit_val;
            end
          end
          if (tick == TICK_LAST) stop_idx_nxt = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
        end
      endcase
    end
  end

  // a commit outranks a simultaneous ready_clr; overrun records prior ready
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      ready      <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      ready      <= 1'b1;
      overrun    <= ready;
      data       <= scratch;
      parity_err <= (PARITY != PAR_NONE) && ((^scratch ^ par_bit) != PAR_EXPECT);
      frame_err  <= stop_low | ~bit_val;
    end else if (ready_clr) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 receiver. It adds configurable data width, optional odd/even parity, 1 or 2 stop bits, an input synchronizer and 3-sample majority voting. It also adds false-start rejection, frame/parity error flags and overrun detection. It sits between the board Rx pin and the downsampling core's byte consumer, driven by the shared baud clken (OVERSAMPLE ticks per bit).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, clken ticks per bit, legal 8..32, must be even
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk_50m  in  1  system clock, 50 MHz; the only clock
rst  in  1  synchronous, active-high reset
clken  in  1  oversample tick; all bit timing counts these ticks only
Rx  in  1  asynchronous serial input, idle high
ready_clr  in  1  consumer acknowledge; clears ready and overrun
ready  out  1  sticky flag: new word available in data
data  out  DATA_BITS  last received word
parity_err  out  1  parity mismatch on the word in data
frame_err  out  1  stop bit(s) sampled low for the word in data
overrun  out  1  a word was committed while ready was still 1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: the only clock is clk_50m; reset is synchronous and active-high.
  - rst=1 at a clk_50m edge puts state in IDLE and clears all counters and scratch.
  - After reset: ready=0, data=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame with no commit.
  - Synchronizer flops reset to 1.
- Input synchronizer: 2-flop synchronizer on Rx produces rx_s, 2 clk_50m cycles latency, clocked every cycle regardless of clken.
- Majority sampling: a 3-deep shift register of rx_s is updated on each clken tick. The bit value is the majority of the samples at tick counts M-1, M and M+1, where M=OVERSAMPLE/2; it is evaluated at tick M+1.
- State machine: IDLE, START, DATA, PARITY, STOP. Transitions happen only on clken ticks. tick counts 0..OVERSAMPLE-1 within a bit and wraps to 0.
  - IDLE: rx_s=0 -> START, tick=1.
  - START: at tick M+1, a majority of 1 means false start -> IDLE; no output changes. At tick OVERSAMPLE-1 -> DATA, bit index=0.
  - DATA: at tick M+1, scratch[bit index] <= majority. After DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
  - PARITY: at tick M+1, capture the parity bit. Parity error = (XOR of scratch XOR parity bit) != (PARITY==1 ? 1 : 0). At tick OVERSAMPLE-1 -> STOP.
  - STOP: the first stop bit is sampled at tick M+1. With STOP_BITS=2, the full first stop bit is counted and the second is sampled at its tick M+1. frame_err is set if any sampled stop bit is 0.
- Commit: happens at the final stop-bit sample tick (mid-bit), then the FSM goes to IDLE, allowing early resync.
  - In the commit cycle: data <= scratch, parity_err and frame_err are updated, ready <= 1.
  - If ready was already 1 at commit, overrun <= 1 and data is overwritten.
  - A frame_err word is still committed; the consumer decides whether to use it.
- ready_clr clears ready and overrun. If ready_clr and a commit occur in the same cycle, the commit wins: ready=1, and overrun reflects ready's prior value.
- parity_err and frame_err change only at commit or reset.
- clken low: the FSM and sample shift register hold; ready_clr is still honoured.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
  - legal-range checks for DATA_BITS, OVERSAMPLE and STOP_BITS (elaboration error)
- One sub-module, uart_rx_sampler: 2-flop synchronizer, 3-sample shift register and majority vote, with outputs rx_s and bit_val.
- The FSM, counters and output registers stay in uart_rx_param.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16), send 0xA5 -> ready=1, data=0xA5, parity_err=0, frame_err=0, overrun=0, commit at tick 9 of the stop bit.
- PARITY=2, send 0x3C with parity bit flipped to 1 -> data=0x3C, parity_err=1. Resend with correct parity 0 -> parity_err=0.
- Stop bit held low for the full bit, byte 0x81 -> data=0x81, frame_err=1, FSM reaches IDLE and accepts the next frame 0x42 correctly.
- Rx low pulse of 4 ticks (ticks 0..3) -> false start; busy returns to 0 by tick 9, ready stays 0. A single 1-tick glitch inside a data bit at tick 8 is outvoted.
- Two frames 0x11, 0x22 without ready_clr -> data=0x22, overrun=1. Pulse ready_clr coincident with a third commit 0x33 -> ready=1, overrun=1. A later ready_clr alone -> ready=0, overrun=0.
- DATA_BITS=7, STOP_BITS=2, PARITY=1: send 0x55 -> data=0x55, no errors. Assert rst during bit 3 of the next frame -> all outputs 0 and busy=0 next cycle; the following frame 0x2A is received cleanly.
